// File: rtl/can_tx_mailbox_scheduler.sv
// rtl/can_tx_mailbox_scheduler.sv - multi-mailbox CAN transmit scheduler in front of a single-buffer controller
//
// Holds NMB host frames, arbitrates on CAN priority, loads the winner over the
// controller register port, strobes transmission, polls for completion and then
// retires, re-arbitrates or retries the frame.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   enable              gate for new arbitration (in-flight frame always completes)
//   cfg_baud, cfg_irqen controller config, written with every DLC load
//   mb_wr/mb_sel/mb_reg/mb_wdata   host write into mailbox storage
//   mb_go, mb_abort     queue / cancel mailbox mb_sel
//   pending/done/err    per-mailbox status (done/err sticky)
//   busy, cur_mb, evt   scheduler status, evt pulses when a done/err bit sets
//   can_cs/can_rs/can_bytesel/can_d/can_q   controller register port

module can_tx_mailbox_scheduler #(
    parameter int NMB       = 4,
    parameter int MAX_RETRY = 3,
    parameter int TMO_W     = 20,
    localparam int MBW      = (NMB > 1) ? $clog2(NMB) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [9:0]       cfg_baud,
    input  logic [2:0]       cfg_irqen,
    input  logic             mb_wr,
    input  logic [MBW-1:0]   mb_sel,
    input  logic [1:0]       mb_reg,
    input  logic [31:0]      mb_wdata,
    input  logic             mb_go,
    input  logic             mb_abort,
    output logic [NMB-1:0]   pending,
    output logic [NMB-1:0]   done,
    output logic [NMB-1:0]   err,
    output logic             busy,
    output logic [MBW-1:0]   cur_mb,
    output logic             evt,
    output logic             can_cs,
    output logic [1:0]       can_rs,
    output logic [3:0]       can_bytesel,
    output logic [31:0]      can_d,
    input  logic [31:0]      can_q
);

    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RW-1:0]    RETRY_MAX = RW'(MAX_RETRY);
    // Poll at which the counter steps onto all ones is the last one.
    localparam logic [TMO_W-1:0] TMO_LAST  = {{(TMO_W-1){1'b1}}, 1'b0};

    typedef enum logic [3:0] {
        IDLE, ARB, WR_ID, WR_D0, WR_D1, WR_DLC, GUARD, POLL, EVAL
    } state_t;

    state_t state, state_nxt;

    logic [31:0] mb_id  [NMB];
    logic [3:0]  mb_dlc [NMB];
    logic [31:0] mb_d0  [NMB];
    logic [31:0] mb_d1  [NMB];

    logic [RW-1:0]    retry_cnt;
    logic [TMO_W-1:0] tmo_cnt;
    logic             guard_cnt;
    logic             abort_req;
    logic             st_ack, st_bit, st_lost, st_tmo;

    logic             win_valid;
    logic [MBW-1:0]   win_idx;
    logic [31:0]      win_key;

    logic             fly_valid;
    logic [MBW-1:0]   fly_mb;
    logic             host_hit;
    logic             eff_abort;
    logic             ev_done, ev_lost, ev_err;
    logic             tmo_last;
    logic [NMB-1:0]   pending_nxt, done_nxt, err_nxt;

    logic             unused_q;
    assign unused_q = ^{can_q[31:15], can_q[11:9], can_q[7:0]};

    // Arbitration key in CAN bit order (lower wins). The extended form carries
    // SRR, IDE and a trailing RTR, so the key is 32 bits; standard IDs pad with
    // zeros, which keeps std-vs-ext ordering decided within the first 13 bits.
    function automatic logic [31:0] prio_key(input logic [31:0] w);
        if (w[31])
            prio_key = {w[28:18], 1'b1, 1'b1, w[17:0], w[30]};
        else
            prio_key = {w[10:0], w[30], 1'b0, 18'h0, 1'b0};
    endfunction

    // Strict less-than keeps the lowest index on equal keys.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        win_key   = '1;
        for (int i = 0; i < NMB; i++) begin
            if (pending[i] && (!win_valid || prio_key(mb_id[i]) < win_key)) begin
                win_valid = 1'b1;
                win_idx   = MBW'(i);
                win_key   = prio_key(mb_id[i]);
            end
        end
    end

    assign busy     = (state != IDLE);
    assign tmo_last = (tmo_cnt == TMO_LAST);

    // During ARB the mailbox about to be latched already counts as in flight,
    // so host accesses to it are protected from the first busy cycle.
    assign fly_mb    = (state == ARB) ? win_idx : cur_mb;
    assign fly_valid = busy && !((state == ARB) && !win_valid);
    assign host_hit  = fly_valid && (mb_sel == fly_mb);

    // An abort arriving in the EVAL cycle itself is honoured too.
    assign eff_abort = abort_req | (mb_abort & host_hit);
    assign ev_done   = st_ack & ~st_bit & ~st_lost & ~st_tmo;
    assign ev_lost   = st_lost & ~st_tmo & ~eff_abort;
    assign ev_err    = st_tmo | eff_abort | (retry_cnt == RETRY_MAX);

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable && |pending) state_nxt = ARB;
            ARB:     state_nxt = win_valid ? WR_ID : IDLE;
            WR_ID:   state_nxt = WR_D0;
            WR_D0:   state_nxt = WR_D1;
            WR_D1:   state_nxt = WR_DLC;
            WR_DLC:  state_nxt = GUARD;
            GUARD:   if (guard_cnt) state_nxt = POLL;
            POLL:    if (!can_q[8] || tmo_last) state_nxt = EVAL;
            EVAL:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Register port drive. Status reads only ever use rs=1; rs=0 is written
    // (ID) but never read, since reading it clears controller RX flags.
    always_comb begin
        can_cs      = 1'b0;
        can_rs      = 2'd0;
        can_bytesel = 4'h0;
        can_d       = 32'h0;
        case (state)
            WR_ID: begin
                can_cs      = 1'b1;
                can_rs      = 2'd0;
                can_bytesel = 4'hF;
                can_d       = mb_id[cur_mb];
            end
            WR_D0: begin
                can_cs      = 1'b1;
                can_rs      = 2'd2;
                can_bytesel = 4'hF;
                can_d       = mb_d0[cur_mb];
            end
            WR_D1: begin
                can_cs      = 1'b1;
                can_rs      = 2'd3;
                can_bytesel = 4'hF;
                can_d       = mb_d1[cur_mb];
            end
            WR_DLC: begin
                can_cs      = 1'b1;
                can_rs      = 2'd1;
                can_bytesel = 4'hF;
                can_d       = {cfg_irqen, 3'b0, cfg_baud, 7'b0, 1'b1, 4'b0, mb_dlc[cur_mb]};
            end
            POLL: begin
                can_cs      = 1'b1;
                can_rs      = 2'd1;
                can_bytesel = 4'h0;
            end
            default: ;
        endcase
    end

    // Mailbox status update: host go/abort first, then the EVAL outcome for
    // cur_mb. The two never collide on one bit because host go/abort to the
    // in-flight mailbox is diverted (dropped / folded into eff_abort).
    always_comb begin
        pending_nxt = pending;
        done_nxt    = done;
        err_nxt     = err;
        if (mb_abort) begin
            if (!host_hit) begin
                pending_nxt[mb_sel] = 1'b0;
                err_nxt[mb_sel]     = 1'b1;
            end
        end else if (mb_go && !host_hit) begin
            pending_nxt[mb_sel] = 1'b1;
            done_nxt[mb_sel]    = 1'b0;
            err_nxt[mb_sel]     = 1'b0;
        end
        if (state == EVAL) begin
            if (ev_done) begin
                pending_nxt[cur_mb] = 1'b0;
                done_nxt[cur_mb]    = 1'b1;
            end else if (!ev_lost && ev_err) begin
                pending_nxt[cur_mb] = 1'b0;
                err_nxt[cur_mb]     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending   <= '0;
            done      <= '0;
            err       <= '0;
            evt       <= 1'b0;
            cur_mb    <= '0;
            retry_cnt <= '0;
            tmo_cnt   <= '0;
            guard_cnt <= 1'b0;
            abort_req <= 1'b0;
            st_ack    <= 1'b0;
            st_bit    <= 1'b0;
            st_lost   <= 1'b0;
            st_tmo    <= 1'b0;
            for (int i = 0; i < NMB; i++) begin
                mb_id[i]  <= '0;
                mb_dlc[i] <= '0;
                mb_d0[i]  <= '0;
                mb_d1[i]  <= '0;
            end
        end else begin
            pending <= pending_nxt;
            done    <= done_nxt;
            err     <= err_nxt;
            evt     <= |((done_nxt & ~done) | (err_nxt & ~err));

            if (mb_wr && !host_hit) begin
                case (mb_reg)
                    2'd0: mb_id[mb_sel]  <= mb_wdata;
                    2'd1: mb_dlc[mb_sel] <= mb_wdata[3:0];
                    2'd2: mb_d0[mb_sel]  <= mb_wdata;
                    2'd3: mb_d1[mb_sel]  <= mb_wdata;
                    default: ;
                endcase
            end

            if (state == EVAL)
                abort_req <= 1'b0;
            else if (mb_abort && host_hit)
                abort_req <= 1'b1;

            guard_cnt <= (state == GUARD);

            if (state == GUARD)
                tmo_cnt <= '0;
            else if (state == POLL)
                tmo_cnt <= tmo_cnt + 1'b1;

            // Status is captured every poll; the last capture is the exit poll.
            if (state == POLL) begin
                st_ack  <= can_q[14];
                st_bit  <= can_q[13];
                st_lost <= can_q[12];
                st_tmo  <= can_q[8] & tmo_last;
            end

            if (state == ARB && win_valid) begin
                cur_mb <= win_idx;
                if (win_idx != cur_mb)
                    retry_cnt <= '0;
            end else if (state == EVAL) begin
                // A retired frame starts its next submission with a fresh count.
                if (ev_done || (!ev_lost && ev_err))
                    retry_cnt <= '0;
                else if (!ev_lost)
                    retry_cnt <= retry_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_can_tx_mailbox_scheduler.sv
// tb/tb_can_tx_mailbox_scheduler.sv - directed self-checking bench for can_tx_mailbox_scheduler

module tb_can_tx_mailbox_scheduler;

    localparam int NMB = 4;
    localparam int MBW = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            enable;
    logic [9:0]      cfg_baud;
    logic [2:0]      cfg_irqen;
    logic            mb_wr;
    logic [MBW-1:0]  mb_sel;
    logic [1:0]      mb_reg;
    logic [31:0]     mb_wdata;
    logic            mb_go;
    logic            mb_abort;
    logic [NMB-1:0]  pending;
    logic [NMB-1:0]  done;
    logic [NMB-1:0]  err;
    logic            busy;
    logic [MBW-1:0]  cur_mb;
    logic            evt;
    logic            can_cs;
    logic [1:0]      can_rs;
    logic [3:0]      can_bytesel;
    logic [31:0]     can_d;
    logic [31:0]     can_q;

    always #5 clk = ~clk;

    can_tx_mailbox_scheduler #(.NMB(NMB), .MAX_RETRY(3), .TMO_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .cfg_baud(cfg_baud), .cfg_irqen(cfg_irqen),
        .mb_wr(mb_wr), .mb_sel(mb_sel), .mb_reg(mb_reg), .mb_wdata(mb_wdata),
        .mb_go(mb_go), .mb_abort(mb_abort),
        .pending(pending), .done(done), .err(err),
        .busy(busy), .cur_mb(cur_mb), .evt(evt),
        .can_cs(can_cs), .can_rs(can_rs), .can_bytesel(can_bytesel),
        .can_d(can_d), .can_q(can_q)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Controller model. mode: 0 ACK, 1 arbitration lost for the first lost_n
    // loads then ACK, 2 no ACK, 3 rts never drops.
    int   mode      = 0;
    int   lat       = 3;
    int   lost_n    = 0;
    int   lost_base = 0;
    logic m_rts     = 1'b0;
    logic m_ack     = 1'b0;
    logic m_bit     = 1'b0;
    logic m_lost    = 1'b0;
    logic m_lose    = 1'b0;
    int   m_cnt     = 0;

    int loads     = 0;
    int polls     = 0;
    int rs0_reads = 0;
    int wr_n      = 0;
    int id_n      = 0;
    int evt_cnt   = 0;
    logic [1:0]  wr_rs  [0:255];
    logic [31:0] wr_d   [0:255];
    logic [31:0] id_log [0:63];

    assign can_q = {17'h0, m_ack, m_bit, m_lost, 3'b0, m_rts, 8'h0};

    always @(negedge clk) begin
        if (evt) evt_cnt++;
        if (can_cs && can_bytesel == 4'hF) begin
            if (wr_n < 256) begin
                wr_rs[wr_n] = can_rs;
                wr_d[wr_n]  = can_d;
            end
            wr_n++;
            if (can_rs == 2'd0) begin
                if (id_n < 64) id_log[id_n] = can_d;
                id_n++;
            end
            if (can_rs == 2'd1 && can_d[8]) begin
                loads++;
                m_rts  = 1'b1;
                m_cnt  = lat;
                m_ack  = 1'b0;
                m_bit  = 1'b0;
                m_lost = 1'b0;
                m_lose = (mode == 1) && ((loads - lost_base) <= lost_n);
            end
        end else begin
            if (can_cs && can_bytesel == 4'h0) begin
                if (can_rs == 2'd0) rs0_reads++;
                if (can_rs == 2'd1) polls++;
            end
            if (m_rts && mode != 3) begin
                m_cnt--;
                if (m_cnt <= 0) begin
                    m_rts = 1'b0;
                    if (mode == 0) m_ack = 1'b1;
                    else if (mode == 1) begin
                        if (m_lose) m_lost = 1'b1;
                        else        m_ack  = 1'b1;
                    end
                end
            end
        end
    end

    task automatic host_wr(input logic [MBW-1:0] sel, input logic [1:0] r, input logic [31:0] data);
        mb_wr = 1'b1; mb_sel = sel; mb_reg = r; mb_wdata = data;
        @(negedge clk);
        mb_wr = 1'b0;
    endtask

    task automatic host_go(input logic [MBW-1:0] sel);
        mb_go = 1'b1; mb_sel = sel;
        @(negedge clk);
        mb_go = 1'b0;
    endtask

    task automatic host_abort(input logic [MBW-1:0] sel);
        mb_abort = 1'b1; mb_sel = sel;
        @(negedge clk);
        mb_abort = 1'b0;
    endtask

    task automatic wait_quiet(input string tag, input int budget);
        for (int i = 0; i < budget && (busy || pending != 0); i++) @(negedge clk);
        check(tag, {27'h0, busy, pending}, 32'h0);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_polls(input int base, input int n);
        for (int i = 0; i < 200 && (polls - base) < n; i++) @(negedge clk);
    endtask

    int wb, ib, lb, pb;

    initial begin
        rst_n = 1'b0; enable = 1'b1; cfg_baud = 10'h2A5; cfg_irqen = 3'b101;
        mb_wr = 1'b0; mb_sel = '0; mb_reg = '0; mb_wdata = '0; mb_go = 1'b0; mb_abort = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_pending", {28'h0, pending}, 32'h0);
        check("rst_done",    {28'h0, done},    32'h0);
        check("rst_err",     {28'h0, err},     32'h0);
        check("rst_busy",    {31'h0, busy},    32'h0);
        check("rst_cur_mb",  {30'h0, cur_mb},  32'h0);
        check("rst_evt",     {31'h0, evt},     32'h0);
        check("rst_cs",      {31'h0, can_cs},  32'h0);
        check("rst_rs",      {30'h0, can_rs},  32'h0);
        check("rst_bytesel", {28'h0, can_bytesel}, 32'h0);
        check("rst_d",       can_d,            32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: single standard frame, full write sequence
        host_wr(0, 2'd0, 32'h0000_0123);
        host_wr(0, 2'd1, 32'h0000_0008);
        host_wr(0, 2'd2, 32'hDEAD_BEEF);
        host_wr(0, 2'd3, 32'h0123_4567);
        wb = wr_n; lb = loads;
        host_go(0);
        wait_quiet("t1_quiet", 200);
        check("t1_nwr",  wr_n - wb, 4);
        check("t1_rs0",  {30'h0, wr_rs[wb]},   32'd0);
        check("t1_d0",   wr_d[wb],             32'h0000_0123);
        check("t1_rs1",  {30'h0, wr_rs[wb+1]}, 32'd2);
        check("t1_d1",   wr_d[wb+1],           32'hDEAD_BEEF);
        check("t1_rs2",  {30'h0, wr_rs[wb+2]}, 32'd3);
        check("t1_d2",   wr_d[wb+2],           32'h0123_4567);
        check("t1_rs3",  {30'h0, wr_rs[wb+3]}, 32'd1);
        check("t1_d3",   wr_d[wb+3],           32'hA2A5_0108);
        check("t1_loads", loads - lb, 1);
        check("t1_done", {28'h0, done}, 32'h1);
        check("t1_err",  {28'h0, err},  32'h0);
        check("t1_evt",  evt_cnt, 1);

        // 2: priority order among std, std+rtr and ext with equal base id
        enable = 1'b0;
        host_wr(1, 2'd0, 32'h0000_0100);
        host_wr(2, 2'd0, 32'h8400_0000);
        host_wr(3, 2'd0, 32'h4000_0100);
        host_go(1); host_go(2); host_go(3);
        ib = id_n;
        enable = 1'b1;
        wait_quiet("t2_quiet", 300);
        check("t2_nid",  id_n - ib, 3);
        check("t2_first",  id_log[ib],   32'h0000_0100);
        check("t2_second", id_log[ib+1], 32'h4000_0100);
        check("t2_third",  id_log[ib+2], 32'h8400_0000);
        check("t2_done", {28'h0, done}, 32'hF);

        // 3: arbitration lost twice, then ACK
        mode = 1; lost_n = 2; lost_base = loads; lb = loads;
        host_go(0);
        wait_quiet("t3_quiet", 300);
        check("t3_loads", loads - lb, 3);
        check("t3_done0", {31'h0, done[0]}, 32'h1);
        check("t3_err0",  {31'h0, err[0]},  32'h0);

        // 4: never ACKed -> initial load plus three retries
        mode = 2; lb = loads;
        host_go(1);
        wait_quiet("t4_quiet", 400);
        check("t4_loads", loads - lb, 4);
        check("t4_err1",  {31'h0, err[1]},  32'h1);
        check("t4_done1", {31'h0, done[1]}, 32'h0);

        // 5a: rts held high -> timeout after 63 polls
        mode = 3; lb = loads; pb = polls;
        host_go(2);
        wait_quiet("t5a_quiet", 300);
        check("t5a_polls", polls - pb, 63);
        check("t5a_loads", loads - lb, 1);
        check("t5a_err2",  {31'h0, err[2]}, 32'h1);

        // 5b: abort on the in-flight mailbox takes effect at EVAL
        mode = 2; lat = 20; lb = loads; pb = polls;
        host_go(3);
        wait_polls(pb, 5);
        host_abort(3);
        check("t5b_defer_err", {31'h0, err[3]},     32'h0);
        check("t5b_defer_pnd", {31'h0, pending[3]}, 32'h1);
        wait_quiet("t5b_quiet", 300);
        check("t5b_err3",  {31'h0, err[3]}, 32'h1);
        check("t5b_loads", loads - lb, 1);

        // 5c: abort on an idle mailbox is immediate
        host_abort(0);
        check("t5c_err0", {31'h0, err[0]},     32'h1);
        check("t5c_pnd0", {31'h0, pending[0]}, 32'h0);

        // 5d: abort mid-poll but the frame succeeds -> done
        mode = 0; pb = polls;
        host_go(1);
        wait_polls(pb, 5);
        host_abort(1);
        wait_quiet("t5d_quiet", 300);
        check("t5d_done1", {31'h0, done[1]}, 32'h1);
        check("t5d_err1",  {31'h0, err[1]},  32'h0);

        // 6: reset during POLL
        pb = polls;
        host_go(2);
        wait_polls(pb, 3);
        check("t6_in_poll", {31'h0, can_cs}, 32'h1);
        rst_n = 1'b0;
        @(negedge clk);
        check("t6_busy",    {31'h0, busy},    32'h0);
        check("t6_cs",      {31'h0, can_cs},  32'h0);
        check("t6_pending", {28'h0, pending}, 32'h0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        check("rs0_reads", rs0_reads, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
